// File: rtl/pong_pkg.sv
// Shared constants for the pong display path: resolution, ball/paddle geometry,
// engine state encoding and score nibble layout.
package pong_pkg;

    localparam int COORD_W  = 11;   // pixel coordinate width
    localparam int CALC_W   = 12;   // one extra bit so sums never wrap
    localparam int NIBBLE_W = 4;    // one player's score

    // score = {left[3:0], right[3:0]}
    localparam int SCORE_LEFT_LSB  = 4;
    localparam int SCORE_RIGHT_LSB = 0;

    localparam int H_RES_DEFAULT          = 1024;
    localparam int V_RES_DEFAULT          = 768;
    localparam int BALL_SIZE_DEFAULT      = 16;
    localparam int PADDLE_W_DEFAULT       = 16;
    localparam int PADDLE_H_DEFAULT       = 128;
    localparam int LEFT_PADDLE_X_DEFAULT  = 32;
    localparam int RIGHT_PADDLE_X_DEFAULT = 976;
    localparam int SERVE_DELAY_DEFAULT    = 60;
    localparam int MAX_SCORE_DEFAULT      = 9;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVE_WAIT = 2'd1,
        ST_MOVE       = 2'd2,
        ST_GAME_OVER  = 2'd3
    } engine_state_t;

    // Ball step in pixels per frame: 2, 4, 6 or 8.
    function automatic logic [CALC_W-1:0] step_size(input logic [1:0] sel);
        return CALC_W'({sel, 1'b0}) + CALC_W'(2);
    endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Counts frame ticks after a serve or a point; done pulses on the
// SERVE_DELAY-th counted tick, which releases the ball.
module pong_serve_timer #(
    parameter int SERVE_DELAY = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic frame_tick,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_DELAY - 1);

    logic [CNT_W-1:0] count;
    logic             running;

    assign done = running && enable && frame_tick && (count == LAST);

    // Restart on start (a tick in the same cycle is not counted), count ticks while armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= '0;
            running <= 1'b1;
        end else if (running && enable && frame_tick) begin
            if (count == LAST) begin
                count   <= '0;
                running <= 1'b0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pong_ball_engine.sv
// Frame-synchronous ball motion, wall/paddle reflection and scoring for pong.
// All outputs are registered; results of a frame_tick appear one cycle later.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int H_RES          = H_RES_DEFAULT,
    parameter int V_RES          = V_RES_DEFAULT,
    parameter int BALL_SIZE      = BALL_SIZE_DEFAULT,
    parameter int PADDLE_W       = PADDLE_W_DEFAULT,
    parameter int PADDLE_H       = PADDLE_H_DEFAULT,
    parameter int LEFT_PADDLE_X  = LEFT_PADDLE_X_DEFAULT,
    parameter int RIGHT_PADDLE_X = RIGHT_PADDLE_X_DEFAULT,
    parameter int SERVE_DELAY    = SERVE_DELAY_DEFAULT,
    parameter int MAX_SCORE      = MAX_SCORE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         enable,
    input  logic         serve,
    input  logic [1:0]   speed_selector,
    input  logic [10:0]  left_palette_pos,
    input  logic [10:0]  right_palette_pos,
    output logic [10:0]  ball_xpos,
    output logic [10:0]  ball_ypos,
    output logic [7:0]   score,
    output logic         point_left,
    output logic         point_right,
    output logic [1:0]   engine_state
);

    localparam logic [COORD_W-1:0] X_CENTRE = COORD_W'((H_RES - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] Y_CENTRE = COORD_W'((V_RES - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] Y_BOTTOM = COORD_W'(V_RES - BALL_SIZE);
    localparam logic [COORD_W-1:0] LEFT_STOP  = COORD_W'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [COORD_W-1:0] RIGHT_STOP = COORD_W'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [CALC_W-1:0]  X_LIMIT    = CALC_W'(H_RES - BALL_SIZE);
    localparam logic [CALC_W-1:0]  Y_LIMIT    = CALC_W'(V_RES - BALL_SIZE);
    localparam logic [CALC_W-1:0]  LEFT_FACE  = CALC_W'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [CALC_W-1:0]  RIGHT_FACE = CALC_W'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [CALC_W-1:0]  BALL_EDGE  = CALC_W'(BALL_SIZE);
    localparam logic [CALC_W-1:0]  PAD_H      = CALC_W'(PADDLE_H);
    localparam logic [NIBBLE_W-1:0] WIN_SCORE = NIBBLE_W'(MAX_SCORE);

    engine_state_t        state, state_n;
    logic [COORD_W-1:0]   x_n, y_n, y_move;
    logic                 dx_right, dy_down, dx_n, dy_n, dy_move;
    logic [7:0]           score_n;
    logic                 point_left_n, point_right_n;
    logic [CALC_W-1:0]    step, x_w, y_w, lp_w, rp_w;
    logic                 ovl_left, ovl_right, hit_left, hit_right, miss_left, miss_right;
    logic [NIBBLE_W-1:0]  left_pts, right_pts, left_inc, right_inc;
    logic                 game_won, timer_start, timer_done;

    assign step      = step_size(speed_selector);
    assign x_w       = CALC_W'(ball_xpos);
    assign y_w       = CALC_W'(ball_ypos);
    assign lp_w      = CALC_W'(left_palette_pos);
    assign rp_w      = CALC_W'(right_palette_pos);
    assign left_pts  = score[SCORE_LEFT_LSB +: NIBBLE_W];
    assign right_pts = score[SCORE_RIGHT_LSB +: NIBBLE_W];
    assign left_inc  = left_pts + NIBBLE_W'(1);
    assign right_inc = right_pts + NIBBLE_W'(1);

    // Paddle contact windows and exits, all judged on the pre-update position.
    assign ovl_left   = (y_w + BALL_EDGE > lp_w) && (y_w < lp_w + PAD_H);
    assign ovl_right  = (y_w + BALL_EDGE > rp_w) && (y_w < rp_w + PAD_H);
    assign hit_left   = !dx_right && (x_w >= LEFT_FACE) && (x_w <= LEFT_FACE + step) && ovl_left;
    assign miss_left  = !dx_right && !hit_left && (x_w < step);
    assign hit_right  = dx_right && (x_w + step >= RIGHT_FACE) && (x_w <= RIGHT_FACE) && ovl_right;
    assign miss_right = dx_right && !hit_right && (x_w + step > X_LIMIT);
    assign game_won   = (miss_left && (right_inc == WIN_SCORE)) ||
                        (miss_right && (left_inc == WIN_SCORE));

    // A fresh serve countdown starts on a serve request or on a point that does not end the game.
    assign timer_start = enable &&
        ((serve && ((state == ST_IDLE) || (state == ST_GAME_OVER))) ||
         ((state == ST_MOVE) && frame_tick && (miss_left || miss_right) && !game_won));

    pong_serve_timer #(
        .SERVE_DELAY (SERVE_DELAY)
    ) u_serve_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (timer_start),
        .frame_tick (frame_tick),
        .enable     (enable),
        .done       (timer_done)
    );

    // Vertical motion with clamping reflection at the top and bottom walls.
    always_comb begin
        y_move  = ball_ypos;
        dy_move = dy_down;
        if (!dy_down) begin
            if (y_w < step) begin
                y_move  = '0;
                dy_move = 1'b1;
            end else begin
                y_move = COORD_W'(y_w - step);
            end
        end else if (y_w + step > Y_LIMIT) begin
            y_move  = Y_BOTTOM;
            dy_move = 1'b0;
        end else begin
            y_move = COORD_W'(y_w + step);
        end
    end

    // Next-state, position, direction and score decisions.
    always_comb begin
        state_n       = state;
        x_n           = ball_xpos;
        y_n           = ball_ypos;
        dx_n          = dx_right;
        dy_n          = dy_down;
        score_n       = score;
        point_left_n  = 1'b0;
        point_right_n = 1'b0;
        if (enable) begin
            unique case (state)
                ST_IDLE: begin
                    if (serve) begin
                        state_n = ST_SERVE_WAIT;
                        dx_n    = 1'b1;
                        dy_n    = 1'b1;
                    end
                end
                ST_SERVE_WAIT: begin
                    if (timer_done) state_n = ST_MOVE;
                end
                ST_MOVE: begin
                    if (frame_tick) begin
                        if (miss_left || miss_right) begin
                            x_n = X_CENTRE;
                            y_n = Y_CENTRE;
                            if (miss_left) begin
                                score_n[SCORE_RIGHT_LSB +: NIBBLE_W] = right_inc;
                                point_right_n = 1'b1;
                                dx_n          = 1'b0;
                            end else begin
                                score_n[SCORE_LEFT_LSB +: NIBBLE_W] = left_inc;
                                point_left_n = 1'b1;
                                dx_n         = 1'b1;
                            end
                            state_n = game_won ? ST_GAME_OVER : ST_SERVE_WAIT;
                        end else begin
                            y_n  = y_move;
                            dy_n = dy_move;
                            if (hit_left) begin
                                x_n  = LEFT_STOP;
                                dx_n = 1'b1;
                            end else if (hit_right) begin
                                x_n  = RIGHT_STOP;
                                dx_n = 1'b0;
                            end else if (dx_right) begin
                                x_n = COORD_W'(x_w + step);
                            end else begin
                                x_n = COORD_W'(x_w - step);
                            end
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (serve) begin
                        score_n = '0;
                        state_n = ST_SERVE_WAIT;
                        dx_n    = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Engine registers; reset returns the ball to centre with a fresh game.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ball_xpos   <= X_CENTRE;
            ball_ypos   <= Y_CENTRE;
            dx_right    <= 1'b1;
            dy_down     <= 1'b1;
            score       <= '0;
            point_left  <= 1'b0;
            point_right <= 1'b0;
        end else begin
            state       <= state_n;
            ball_xpos   <= x_n;
            ball_ypos   <= y_n;
            dx_right    <= dx_n;
            dy_down     <= dy_n;
            score       <= score_n;
            point_left  <= point_left_n;
            point_right <= point_right_n;
        end
    end

    assign engine_state = state;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: directed serve/freeze/reset steps
// plus randomized play compared every cycle against a behavioural game model.
module tb_pong_ball_engine;

    localparam int SERVE_DELAY = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b1;
    logic        serve = 1'b0;
    logic [1:0]  speed_selector = 2'd0;
    logic [10:0] left_palette_pos = 11'd0;
    logic [10:0] right_palette_pos = 11'd0;
    logic [10:0] ball_xpos, ball_ypos;
    logic [7:0]  score;
    logic        point_left, point_right;
    logic [1:0]  engine_state;

    pong_ball_engine dut (
        .clk               (clk),
        .rst               (rst),
        .frame_tick        (frame_tick),
        .enable            (enable),
        .serve             (serve),
        .speed_selector    (speed_selector),
        .left_palette_pos  (left_palette_pos),
        .right_palette_pos (right_palette_pos),
        .ball_xpos         (ball_xpos),
        .ball_ypos         (ball_ypos),
        .score             (score),
        .point_left        (point_left),
        .point_right       (point_right),
        .engine_state      (engine_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Game model: 0 idle, 1 waiting to serve, 2 in play, 3 game over; directions +1/-1.
    int m_state, m_x, m_y, m_dx, m_dy, m_l, m_r, m_cnt, m_pl, m_pr;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ball_xpos", 32'(ball_xpos), m_x);
        chk("ball_ypos", 32'(ball_ypos), m_y);
        chk("score", 32'(score), m_l * 16 + m_r);
        chk("point_left", 32'(point_left), m_pl);
        chk("point_right", 32'(point_right), m_pr);
        chk("engine_state", 32'(engine_state), m_state);
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 504; m_y = 376; m_dx = 1; m_dy = 1;
        m_l = 0; m_r = 0; m_cnt = 0; m_pl = 0; m_pr = 0;
    endtask

    task automatic model_move();
        int s, lp, rp, nx, ny, ndx, ndy, scorer;
        bit over_l, over_r;
        s  = 2 * (int'(speed_selector) + 1);
        lp = int'(left_palette_pos);
        rp = int'(right_palette_pos);
        nx = m_x; ny = m_y; ndx = m_dx; ndy = m_dy; scorer = 0;
        if (m_dy < 0) begin
            if (m_y < s) begin ny = 0; ndy = 1; end else ny = m_y - s;
        end else begin
            if (m_y + s > 752) begin ny = 752; ndy = -1; end else ny = m_y + s;
        end
        over_l = (m_y + 16 > lp) && (m_y < lp + 128);
        over_r = (m_y + 16 > rp) && (m_y < rp + 128);
        if (m_dx < 0) begin
            if (m_x >= 48 && m_x <= 48 + s && over_l) begin nx = 48; ndx = 1; end
            else if (m_x < s) scorer = 2;
            else nx = m_x - s;
        end else begin
            if (m_x >= 960 - s && m_x <= 960 && over_r) begin nx = 960; ndx = -1; end
            else if (m_x + s > 1008) scorer = 1;
            else nx = m_x + s;
        end
        if (scorer != 0) begin
            m_x = 504; m_y = 376; m_cnt = 0;
            if (scorer == 1) begin m_l++; m_pl = 1; m_dx = 1; end
            else begin m_r++; m_pr = 1; m_dx = -1; end
            m_state = (m_l == 9 || m_r == 9) ? 3 : 1;
        end else begin
            m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            model_reset();
            return;
        end
        m_pl = 0; m_pr = 0;
        if (!enable) return;
        case (m_state)
            0: if (serve) begin m_state = 1; m_cnt = 0; m_dx = 1; m_dy = 1; end
            1: if (frame_tick) begin
                   m_cnt++;
                   if (m_cnt == SERVE_DELAY) m_state = 2;
               end
            2: if (frame_tick) model_move();
            default: if (serve) begin m_l = 0; m_r = 0; m_state = 1; m_cnt = 0; m_dx = 1; end
        endcase
    endtask

    // One clock: drive inputs, let the edge pass, advance the model, check 1 ns later.
    task automatic cyc(input bit t, input bit s, input bit e, input bit r);
        frame_tick = t; serve = s; enable = e; rst = r;
        @(posedge clk);
        model_clock();
        #1;
        frame_tick = 1'b0; serve = 1'b0; rst = 1'b0;
        check_all();
    endtask

    task automatic randomize_inputs();
        speed_selector = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) left_palette_pos = 11'((m_y >= 40) ? m_y - 40 : 0);
        else left_palette_pos = 11'($urandom_range(0, 700));
        if ($urandom_range(0, 1) == 1) right_palette_pos = 11'((m_y >= 40) ? m_y - 40 : 0);
        else right_palette_pos = 11'($urandom_range(0, 700));
    endtask

    initial begin
        int budget;
        int saved_x, saved_y;
        model_reset();

        // Reset state.
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        chk("reset_x", 32'(ball_xpos), 504);
        chk("reset_y", 32'(ball_ypos), 376);
        chk("reset_state", 32'(engine_state), 0);

        // Idle ignores ticks; serve coinciding with a tick does not count that tick.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        for (int i = 0; i < SERVE_DELAY - 1; i++) cyc(1, 0, 1, 0);
        chk("serve_wait_59", 32'(engine_state), 1);
        cyc(1, 0, 1, 0);
        chk("release_state", 32'(engine_state), 2);
        chk("release_x", 32'(ball_xpos), 504);
        speed_selector = 2'd0;
        cyc(1, 0, 1, 0);
        chk("first_step_x", 32'(ball_xpos), 506);
        chk("first_step_y", 32'(ball_ypos), 378);

        // Randomized play to game over; inputs also change between ticks.
        budget = 0;
        while (m_state != 3 && budget < 60000) begin
            randomize_inputs();
            if ($urandom_range(0, 1) == 1) begin
                cyc(0, 1'($urandom_range(0, 7) == 0), 1, 0);
                budget++;
                saved_x = m_y;
                randomize_inputs();
                left_palette_pos  = 11'($urandom_range(0, 1) == 1 ? 0 : 2000);
                if (saved_x > 0) right_palette_pos = 11'($urandom_range(0, 700));
                cyc(0, 0, 1, 0);
                budget++;
                randomize_inputs();
            end
            cyc(1, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) != 0), 0);
            budget++;
        end
        chk("game_over_state", 32'(engine_state), 3);
        chk("game_over_winner", 32'(score[7:4] == 4'd9 || score[3:0] == 4'd9), 1);

        // Game over holds; serve clears the score.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        chk("restart_score", 32'(score), 0);
        chk("restart_state", 32'(engine_state), 1);

        // Serve again, play a few frames, then freeze.
        budget = 0;
        while (m_state != 2 && budget < 200) begin
            cyc(1, 0, 1, 0);
            budget++;
        end
        chk("second_release", 32'(engine_state), 2);
        for (int i = 0; i < 3; i++) begin
            speed_selector = 2'($urandom_range(0, 3));
            cyc(1, 0, 1, 0);
        end
        saved_x = m_x;
        saved_y = m_y;
        for (int i = 0; i < 10; i++) begin
            randomize_inputs();
            cyc(1, 1'($urandom_range(0, 1)), 0, 0);
        end
        chk("freeze_x", 32'(ball_xpos), saved_x);
        chk("freeze_y", 32'(ball_ypos), saved_y);
        cyc(1, 0, 1, 0);

        // Reset in the middle of play.
        cyc(1, 0, 1, 1);
        chk("mid_reset_x", 32'(ball_xpos), 504);
        chk("mid_reset_y", 32'(ball_ypos), 376);
        chk("mid_reset_state", 32'(engine_state), 0);
        chk("mid_reset_score", 32'(score), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
